// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared constants and types for the times-table BRAM arbiter
// Holds the default operand/result widths, the RAM depth, the controller
// state type and the requester id type. No ports.
package tt_pkg;

    localparam int TT_OPW   = 3;
    localparam int TT_RW    = 2 * TT_OPW;
    localparam int TT_DEPTH = 1 << (2 * TT_OPW);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } tt_state_e;

    typedef logic tt_req_id_t;

endpackage

// File: rtl/tt_bram_arbiter_rr_arb2.sv
// rtl/tt_bram_arbiter_rr_arb2.sv - two-input round-robin arbiter
// Ports: clk, rst (async, active-high); en_i enables granting; valid_i[1:0]
// requests; grant_o[1:0] one-hot grant. Every grant is taken as accepted, so
// the priority pointer advances on any grant and holds otherwise.
module rr_arb2
    import tt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    // Requester that wins the next contended cycle; 0 after reset.
    tt_req_id_t prio_q, prio_d;

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = prio_q ? 2'b10 : 2'b01;
                default: grant_o = 2'b00;
            endcase
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (grant_o[0]) begin
            prio_d = 1'b1;
        end else if (grant_o[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/tt_bram_arbiter.sv
// rtl/tt_bram_arbiter.sv - times-table BRAM fill controller and 2-port lookup arbiter
// After reset fills the external RAM with a*b at address {a,b}, then shares the
// RAM read port between two requesters with round-robin arbitration.
// Ports: clk, rst (async, active-high); req0/req1 valid/a/b in, ready out;
// rsp0/rsp1 valid/data out; init_done; err; bram_ena/wea/addra/dina out,
// bram_douta in. Optional macro TT_SELFCHECK_EN checks each read result.
module tt_bram_arbiter
    import tt_pkg::*;
#(
    parameter int OPW        = TT_OPW,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [OPW-1:0]       req0_a,
    input  logic [OPW-1:0]       req0_b,
    output logic                 req0_ready,
    output logic                 rsp0_valid,
    output logic [2*OPW-1:0]     rsp0_data,
    input  logic                 req1_valid,
    input  logic [OPW-1:0]       req1_a,
    input  logic [OPW-1:0]       req1_b,
    output logic                 req1_ready,
    output logic                 rsp1_valid,
    output logic [2*OPW-1:0]     rsp1_data,
    output logic                 init_done,
    output logic                 err,
    output logic                 bram_ena,
    output logic                 bram_wea,
    output logic [2*OPW-1:0]     bram_addra,
    output logic [2*OPW-1:0]     bram_dina,
    input  logic [2*OPW-1:0]     bram_douta
);

    localparam int AW = 2 * OPW;
    localparam int RW = 2 * OPW;

    tt_state_e       state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            init_done_q, init_done_d;

    logic [1:0]      grant;
    logic            xfer0, xfer1, xfer;
    tt_req_id_t      win_id;
    logic [OPW-1:0]  win_a, win_b;

    // Response tracking: valid flag and requester id per RAM latency stage.
    logic [RD_LATENCY-1:0] pv_q, pv_d;
    logic [RD_LATENCY-1:0] pid_q, pid_d;
    logic                  vld_last;
    tt_req_id_t            id_last;

    logic            rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic [RW-1:0]   rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en_i    (init_done_q),
        .valid_i ({req1_valid, req0_valid}),
        .grant_o (grant)
    );

    assign req0_ready = init_done_q & grant[0];
    assign req1_ready = init_done_q & grant[1];
    assign xfer0      = req0_valid & req0_ready;
    assign xfer1      = req1_valid & req1_ready;
    assign xfer       = xfer0 | xfer1;
    assign win_id     = xfer1;
    assign win_a      = xfer1 ? req1_a : req0_a;
    assign win_b      = xfer1 ? req1_b : req0_b;
    assign vld_last   = pv_q[RD_LATENCY-1];
    assign id_last    = pid_q[RD_LATENCY-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d     = ST_SERVE;
                    init_done_d = 1'b1;
                end
            end
            ST_SERVE: begin
                state_d = ST_SERVE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // RAM port is combinational so the write/read lands on the same edge that
    // advances the fill counter or accepts the lookup. Held idle during reset.
    always_comb begin
        bram_ena   = 1'b0;
        bram_wea   = 1'b0;
        bram_addra = '0;
        bram_dina  = '0;
        if (!rst) begin
            if (state_q == ST_INIT) begin
                bram_ena   = 1'b1;
                bram_wea   = 1'b1;
                bram_addra = cnt_q;
                bram_dina  = RW'(cnt_q[AW-1:OPW]) * RW'(cnt_q[OPW-1:0]);
            end else if (xfer) begin
                bram_ena   = 1'b1;
                bram_addra = {win_a, win_b};
            end
        end
    end

    always_comb begin
        pv_d     = '0;
        pid_d    = '0;
        pv_d[0]  = xfer;
        pid_d[0] = win_id;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pv_d[i]  = pv_q[i-1];
            pid_d[i] = pid_q[i-1];
        end
        rsp0_valid_d = vld_last & ~id_last;
        rsp1_valid_d = vld_last &  id_last;
        rsp0_data_d  = rsp0_valid_d ? bram_douta : rsp0_data_q;
        rsp1_data_d  = rsp1_valid_d ? bram_douta : rsp1_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            init_done_q  <= 1'b0;
            pv_q         <= '0;
            pid_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_done_q  <= init_done_d;
            pv_q         <= pv_d;
            pid_q        <= pid_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    assign init_done  = init_done_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;

`ifdef TT_SELFCHECK_EN
    // Operands travel alongside the id so the returning word can be checked.
    logic [OPW-1:0] pa_q [RD_LATENCY];
    logic [OPW-1:0] pa_d [RD_LATENCY];
    logic [OPW-1:0] pb_q [RD_LATENCY];
    logic [OPW-1:0] pb_d [RD_LATENCY];
    logic           err_q, err_d;

    always_comb begin
        pa_d    = pa_q;
        pb_d    = pb_q;
        pa_d[0] = win_a;
        pb_d[0] = win_b;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pa_d[i] = pa_q[i-1];
            pb_d[i] = pb_q[i-1];
        end
        err_d = err_q | (vld_last &
                (bram_douta != RW'(pa_q[RD_LATENCY-1]) * RW'(pb_q[RD_LATENCY-1])));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pa_q  <= '{default: '0};
            pb_q  <= '{default: '0};
            err_q <= 1'b0;
        end else begin
            pa_q  <= pa_d;
            pb_q  <= pb_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tt_bram_arbiter.sv
// tb/tb_tt_bram_arbiter.sv - scoreboard bench for tt_bram_arbiter with a RAM model
module tb_tt_bram_arbiter;
    import tt_pkg::*;

    localparam int RD_LAT = 1;
`ifdef TT_SELFCHECK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [2:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic [5:0] rsp0_data, rsp1_data;
    logic       init_done, err;
    logic       bram_ena, bram_wea;
    logic [5:0] bram_addra, bram_dina, bram_douta;

    logic       corrupt;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         wr_cnt = 0;

    typedef struct {
        int port;
        int data;
        int cyc;
    } exp_t;
    exp_t sb[$];

    tt_bram_arbiter #(.OPW(3), .RD_LATENCY(RD_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .init_done  (init_done),
        .err        (err),
        .bram_ena   (bram_ena),
        .bram_wea   (bram_wea),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_douta (bram_douta)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: write-enable stores, read returns after RD_LAT edges.
    logic [5:0] mem [TT_DEPTH];
    logic [5:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (bram_ena && bram_wea) mem[bram_addra] <= bram_dina;
        if (bram_ena && !bram_wea) rd_pipe[0] <= corrupt ? 6'd0 : mem[bram_addra];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_douta = rd_pipe[RD_LAT-1];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_rsp(input int port, input int data);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_rsp: got port %0d data %0d expected none", port, data);
        end else begin
            e = sb.pop_front();
            chk("rsp_port", port, e.port);
            chk("rsp_data", data, e.data);
            chk("rsp_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor: fill writes and responses, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                wr_cnt = 0;
            end else begin
                if (bram_ena && bram_wea) begin
                    chk("fill_addr", bram_addra, wr_cnt);
                    chk("fill_data", bram_dina, (wr_cnt / 8) * (wr_cnt % 8));
                    chk("ready_in_init", {req1_ready, req0_ready}, 0);
                    wr_cnt = wr_cnt + 1;
                end
                if (rsp0_valid) check_rsp(0, rsp0_data);
                if (rsp1_valid) check_rsp(1, rsp1_data);
            end
        end
    end

    task automatic lk(input bit v0, input int a0, input int b0,
                      input bit v1, input int a1, input int b1,
                      input bit g0, input bit g1, input bit keep);
        exp_t e;
        logic [2:0] ta0, tb0, ta1, tb1;
        ta0 = a0[2:0]; tb0 = b0[2:0]; ta1 = a1[2:0]; tb1 = b1[2:0];
        @(negedge clk);
        #1;
        req0_valid = v0; req0_a = ta0; req0_b = tb0;
        req1_valid = v1; req1_a = ta1; req1_b = tb1;
        #1;
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        if (g0 || g1) chk("rd_addr", bram_addra, g0 ? a0 * 8 + b0 : a1 * 8 + b1);
        if (keep && g0) begin
            e = '{0, corrupt ? 0 : a0 * b0, cyc + 1 + RD_LAT};
            sb.push_back(e);
        end
        if (keep && g1) begin
            e = '{1, corrupt ? 0 : a1 * b1, cyc + 1 + RD_LAT};
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) lk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        #2;
        chk("rst_init_done", init_done, 0);
        chk("rst_err", err, 0);
        chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("rst_rsp0_data", rsp0_data, 0);
        chk("rst_rsp1_data", rsp1_data, 0);
        chk("rst_bram_ctl", {bram_ena, bram_wea}, 0);
        chk("rst_bram_addra", bram_addra, 0);
        chk("rst_bram_dina", bram_dina, 0);
        chk("rst_ready", {req1_ready, req0_ready}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_init();
        repeat (TT_DEPTH) @(negedge clk);
        #2;
        chk("fill_count", wr_cnt, TT_DEPTH);
        chk("init_done_before_last_edge", init_done, 0);
        @(negedge clk);
        #2;
        chk("init_done_after_fill", init_done, 1);
        chk("fill_count_final", wr_cnt, TT_DEPTH);
        chk("no_write_in_serve", bram_wea, 0);
    endtask

    initial begin
        exp_t e;
        rst = 1'b0;
        corrupt = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        #1 rst = 1'b1;

        do_reset();
        check_init();

        // Contention from reset pointer: req0 first, then req1.
        lk(1, 3, 5, 1, 7, 7, 1, 0, 1);
        lk(0, 0, 0, 1, 7, 7, 0, 1, 1);
        // Single requesters.
        lk(1, 7, 6, 0, 0, 0, 1, 0, 1);
        idle(3);
        lk(0, 0, 0, 1, 5, 4, 0, 1, 1);
        // Both held valid: strict alternation starting with requester 0.
        for (int i = 0; i < 6; i++) lk(1, 2, 3, 1, 4, 5, (i % 2) == 0, (i % 2) == 1, 1);
        idle(4);
        chk("sb_drained_1", sb.size(), 0);

        // Reset with lookups in flight: their responses must vanish.
        lk(1, 1, 1, 0, 0, 0, 1, 0, 0);
        lk(0, 0, 0, 1, 2, 2, 0, 1, 0);
        do_reset();
        // Request held through the refill; accepted only once init_done is set.
        req0_valid = 1'b1; req0_a = 3'd6; req0_b = 3'd7;
        check_init();
        chk("req0_ready_after_init", req0_ready, 1);
        e = '{0, 42, cyc + 1 + RD_LAT};
        sb.push_back(e);
        idle(3);
        chk("err_clean", err, 0);

        // Corrupted read word.
        corrupt = 1'b1;
        lk(1, 2, 3, 0, 0, 0, 1, 0, 1);
        @(posedge clk);
        #1;
        corrupt = 1'b0;
        req0_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2;
        chk("err_on_rsp", err, EXP_ERR);
        idle(3);
        chk("err_sticky", err, EXP_ERR);
        chk("sb_drained_2", sb.size(), 0);

        do_reset();
        idle(2);
        chk("err_after_rst", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/tt_bram_arbiter.md
Name: tt_bram_arbiter

Overview:
- Front-end controller for the 64x6 times-table block RAM (address {a,b}, data a*b).
- After reset it fills the RAM with the 0..7 x 0..7 products through the RAM write port.
- It then shares the single RAM read port between two requesters with round-robin arbitration.
- It sits between the lookup clients and the RAM instance; the RAM itself is external, connected via the bram_* ports.

Parameters:
OPW, 3, operand width; address width = 2*OPW, data width RW = 2*OPW, depth = 2^(2*OPW)
RD_LATENCY, 1, RAM read latency in cycles (legal 1 or 2), edge of ena/addr capture to douta valid

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 lookup request
req0_a  in  OPW  requester 0 operand a
req0_b  in  OPW  requester 0 operand b
req0_ready  out  1  requester 0 accepted this cycle
rsp0_valid  out  1  requester 0 result valid (one-cycle pulse)
rsp0_data  out  RW  requester 0 result
req1_valid, req1_a, req1_b, req1_ready, rsp1_valid, rsp1_data: same as requester 0, for requester 1
init_done  out  1  RAM fill complete, lookups permitted
err  out  1  sticky self-check error (see Optional Feature)
bram_ena  out  1  RAM enable
bram_wea  out  1  RAM write enable
bram_addra  out  2*OPW  RAM address
bram_dina  out  RW  RAM write data
bram_douta  in  RW  RAM read data

Behaviour:
- One clock domain (clk); reset is asynchronous and active-high (rst).
- Reset values: init_done=0, err=0, rsp*_valid=0, rsp*_data=0, bram_ena=0, bram_wea=0, bram_addra=0, bram_dina=0, fill counter=0, rr pointer=0 (requester 0 favoured).
- FSM states: INIT, SERVE.
- INIT:
  - Each cycle: bram_ena=1, bram_wea=1, bram_addra=cnt, bram_dina=cnt[2*OPW-1:OPW]*cnt[OPW-1:0] (product zero-extended to RW); cnt increments.
  - req*_ready=0.
  - After the write at cnt=2^(2*OPW)-1, move to SERVE and set init_done=1 on that edge. For OPW=3 that is the 64th clock after rst deasserts.
- SERVE, each cycle:
  - Only one valid: grant it.
  - Both valid: grant the requester opposite to the rr pointer's last grant.
  - Grant updates the pointer; no grant leaves it unchanged.
  - reqN_ready = init_done & grantN, combinational; transfer = valid & ready.
  - On transfer: bram_ena=1, bram_wea=0, bram_addra={a,b} of the winner. With no transfer, bram_ena=0.
  - Throughput: one lookup per cycle total.
- Response path:
  - A 1-bit id and valid flag are shifted through a RD_LATENCY-deep pipeline.
  - rspN_valid pulses exactly RD_LATENCY cycles after the transfer edge.
  - rspN_data = bram_douta, registered into the pipeline output so it is held until the next response to that port.
  - Responses cannot be back-pressured and are returned in acceptance order.
- Simultaneous events:
  - A request arriving in the same cycle init_done rises is not accepted until the next cycle, because ready is qualified by the registered init_done.
  - An unchanged valid held across cycles is a new request each accepted cycle.
- Reset mid-operation:
  - In-flight responses are dropped (no rsp pulse after reset).
  - FSM returns to INIT; fill restarts at address 0; rr pointer returns to 0.

Optional Feature:
TT_SELFCHECK_EN
- Defined:
  - Each pipelined response compares bram_douta with a*b computed from operands carried in the pipeline.
  - A mismatch sets err=1 on the response edge; err stays set until rst.
- Undefined:
  - Operands are not pipelined; err is tied 0.
  - Port list is unchanged.

Decomposition:
- Shared package tt_pkg holds:
  - OPW and RW defaults, depth constant.
  - FSM state typedef (INIT, SERVE).
  - requester-id typedef.
- One sub-module, rr_arb2: 2-input round-robin arbiter (valid in, grant out, pointer register, advance on accept).

Test Plan:
- Reset then idle: 64 writes observed, bram_dina=49 at bram_addra=63, bram_dina=0 at addr 0; init_done=1 after the 64th write edge; no ready during INIT.
- After init, req0 a=7 b=6 alone: req0_ready=1 same cycle; rsp0_valid pulse RD_LATENCY cycles later, rsp0_data=42; rsp1_valid stays 0.
- Both valid from reset pointer, req0 a=3 b=5, req1 a=7 b=7: req0 granted first (15), req1 next cycle (49); responses in that order, one per cycle.
- Both held valid for 6 cycles: grants alternate 0,1,0,1,0,1; each gets 3 results.
- Assert rst with two lookups in flight: no rsp pulses; fill restarts at addr 0; init_done=0 until refill done.
- TT_SELFCHECK_EN: force bram_douta=0 for a lookup a=2 b=3; err=1 on that response edge and stays 1 until rst. Without the macro err stays 0.
